// File: rtl/proc_pkg.sv
// Shared definitions for the bus-processor control unit.
//   OPW, REGW       : instruction field widths (opcode, register index)
//   OP_*            : opcode encodings of IR[8:6]
//   state_t         : 2-bit step counter T0..T3
package proc_pkg;

  localparam int unsigned OPW  = 3;
  localparam int unsigned REGW = 3;

  localparam logic [OPW-1:0] OP_MV   = 3'b000;
  localparam logic [OPW-1:0] OP_MVI  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD  = 3'b010;
  localparam logic [OPW-1:0] OP_SUB  = 3'b011;
  localparam logic [OPW-1:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

endpackage

// File: rtl/proc_ctrl_onehot.sv
// Enabled binary-to-one-hot decoder for register indices.
//   en     : when low the output is all zeros
//   idx    : REGW-bit register index
//   onehot : NREGS-bit one-hot select
module proc_ctrl_onehot
  import proc_pkg::*;
#(
  parameter int unsigned REGW  = proc_pkg::REGW,
  parameter int unsigned NREGS = 8
) (
  input  logic             en,
  input  logic [REGW-1:0]  idx,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl.sv
// Control unit for the 9-bit bus processor. Steps each instruction through T0..T3 and
// drives register load enables, one-hot bus-source selects, ALU mode, Done and Busy.
// Outputs are combinational from state, IR and Run (Run only matters in T0).
//   Clock, Resetn : rising-edge clock, asynchronous active-low reset
//   Run           : start request, sampled in T0
//   IR            : {opcode, X, Y}
//   GNZ           : G non-zero flag (mvnz only)
//   IRin, Rin, Ain, Gin           : load enables
//   Rout, DINout, Gout            : bus source selects (at most one active)
//   AddSub, Done, Busy            : ALU mode, end-of-instruction pulse, T1..T3 flag
// Build option: define PROC_CTRL_MVNZ_EN to decode opcode 100 as mvnz Rx,Ry.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned OPW   = proc_pkg::OPW,
  parameter int unsigned REGW  = proc_pkg::REGW,
  parameter int unsigned NREGS = 8
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Run,
  input  logic [OPW+2*REGW-1:0] IR,
  input  logic                  GNZ,
  output logic                  IRin,
  output logic [NREGS-1:0]      Rin,
  output logic [NREGS-1:0]      Rout,
  output logic                  DINout,
  output logic                  Gout,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  AddSub,
  output logic                  Done,
  output logic                  Busy
);

  state_t          state;
  logic [OPW-1:0]  op;
  logic [REGW-1:0] rx;
  logic [REGW-1:0] ry;
  logic            rin_x;
  logic            rout_x;
  logic            rout_y;
  logic [NREGS-1:0] x_oh;
  logic [NREGS-1:0] y_oh;

  assign op = IR[OPW+2*REGW-1 -: OPW];
  assign rx = IR[2*REGW-1 -: REGW];
  assign ry = IR[REGW-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
    end else begin
      case (state)
        T0:      if (Run) state <= T1;
        T1:      state <= (op == OP_ADD || op == OP_SUB) ? T2 : T0;
        T2:      state <= T3;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    IRin   = 1'b0;
    DINout = 1'b0;
    Gout   = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    rin_x  = 1'b0;
    rout_x = 1'b0;
    rout_y = 1'b0;
    case (state)
      // Gated by Resetn so a held Run cannot assert IRin during reset.
      T0: IRin = Run & Resetn;
      T1: begin
        case (op)
          OP_MV: begin
            rout_y = 1'b1;
            rin_x  = 1'b1;
            Done   = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            rin_x  = 1'b1;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_x = 1'b1;
            Ain    = 1'b1;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            rout_y = 1'b1;
            rin_x  = GNZ;
            Done   = 1'b1;
          end
`endif
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        rout_y = 1'b1;
        Gin    = 1'b1;
        AddSub = (op == OP_SUB);
      end
      default: begin
        Gout  = 1'b1;
        rin_x = 1'b1;
        Done  = 1'b1;
      end
    endcase
  end

`ifndef PROC_CTRL_MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = GNZ;
`endif

  // X is never both loaded and driven in the same step, so one decoder serves both.
  proc_ctrl_onehot #(
    .REGW  (REGW),
    .NREGS (NREGS)
  ) u_dec_x (
    .en     (rin_x | rout_x),
    .idx    (rx),
    .onehot (x_oh)
  );

  proc_ctrl_onehot #(
    .REGW  (REGW),
    .NREGS (NREGS)
  ) u_dec_y (
    .en     (rout_y),
    .idx    (ry),
    .onehot (y_oh)
  );

  assign Rin  = x_oh & {NREGS{rin_x}};
  assign Rout = (x_oh & {NREGS{rout_x}}) | y_oh;
  assign Busy = (state != T0);

endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: cycle-by-cycle vector table plus hand-written reset sequences.
// Expected output words are queued when inputs are driven and popped at the falling edge.
module tb_proc_ctrl;

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       GNZ;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;
  logic       Busy;

  proc_ctrl dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .IR     (IR),
    .GNZ    (GNZ),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .DINout (DINout),
    .Gout   (Gout),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done),
    .Busy   (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Busy}
  logic [23:0] got;
  assign got = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Busy};

  localparam logic [23:0] ZERO = '0;

  typedef struct {
    logic        run;
    logic [8:0]  ir;
    logic        gnz;
    logic [23:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] sb[$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [23:0] mk(input logic irin, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic din,
                                     input logic gout, input logic ain, input logic gin,
                                     input logic addsub, input logic done,
                                     input logic busy);
    return {irin, rin, rout, din, gout, ain, gin, addsub, done, busy};
  endfunction

  task automatic add_vec(input logic run, input logic [8:0] ir, input logic gnz,
                         input logic [23:0] exp, input string name);
    vec_t v;
    v.run  = run;
    v.ir   = ir;
    v.gnz  = gnz;
    v.exp  = exp;
    v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input string name);
    logic [23:0] exp;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
      return;
    end
    exp = sb.pop_front();
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
    total++;
    if ($countones({Rout, DINout, Gout}) > 1) begin
      bad++;
      $display("FAIL %s_bus: %0d bus sources active, at most 1 allowed", name,
               $countones({Rout, DINout, Gout}));
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check at the falling edge.
  task automatic step(input logic run, input logic [8:0] ir, input logic gnz,
                      input logic [23:0] exp, input string name);
    @(posedge Clock);
    #1;
    Run = run;
    IR  = ir;
    GNZ = gnz;
    sb.push_back(exp);
    @(negedge Clock);
    check(name);
  endtask

  localparam logic [8:0] I_MVI3  = 9'b001_011_000;
  localparam logic [8:0] I_ADD12 = 9'b010_001_010;
  localparam logic [8:0] I_SUB55 = 9'b011_101_101;
  localparam logic [8:0] I_MV70  = 9'b000_111_000;
  localparam logic [8:0] I_ILL   = 9'b101_010_011;
  localparam logic [8:0] I_MVNZ  = 9'b100_000_001;
  localparam logic [8:0] I_ILL7  = 9'b111_000_000;
  localparam logic [8:0] I_MV21  = 9'b000_010_001;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [23:0] e_fetch;
    logic [23:0] e_mvnz0;
    logic [23:0] e_mvnz1;
    e_fetch = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0);
`ifdef PROC_CTRL_MVNZ_EN
    e_mvnz0 = mk(0, 8'h00, 8'h02, 0, 0, 0, 0, 0, 1, 1);
    e_mvnz1 = mk(0, 8'h01, 8'h02, 0, 0, 0, 0, 0, 1, 1);
`else
    e_mvnz0 = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1);
    e_mvnz1 = e_mvnz0;
`endif

    // Reset with Run held high: everything stays low.
    Resetn = 1'b0;
    Run    = 1'b1;
    IR     = I_MVI3;
    GNZ    = 1'b0;
    @(negedge Clock);
    sb.push_back(ZERO);
    check("reset_hold");
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    sb.push_back(e_fetch);
    #1;
    check("reset_release_irin");
    step(0, I_MVI3, 0, mk(0, 8'h08, 8'h00, 1, 0, 0, 0, 0, 1, 1), "mvi_t1");
    step(0, I_MVI3, 0, ZERO, "mvi_back_t0");

    // Cycle-by-cycle vectors, starting in T0.
    add_vec(1, I_ADD12, 0, e_fetch, "add_t0");
    add_vec(0, I_ADD12, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 1), "add_t1");
    add_vec(1, I_ADD12, 0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 1), "add_t2");
    add_vec(1, I_ADD12, 0, mk(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1, 1), "add_t3");
    add_vec(1, I_SUB55, 0, e_fetch, "sub_t0_b2b");
    add_vec(1, I_SUB55, 0, mk(0, 8'h00, 8'h20, 0, 0, 1, 0, 0, 0, 1), "sub_t1");
    add_vec(1, I_SUB55, 0, mk(0, 8'h00, 8'h20, 0, 0, 0, 1, 1, 0, 1), "sub_t2");
    add_vec(0, I_SUB55, 0, mk(0, 8'h20, 8'h00, 0, 1, 0, 0, 0, 1, 1), "sub_t3");
    add_vec(0, I_SUB55, 0, ZERO, "idle_t0");
    add_vec(1, I_MV70, 0, e_fetch, "mv_t0");
    add_vec(0, I_MV70, 0, mk(0, 8'h80, 8'h01, 0, 0, 0, 0, 0, 1, 1), "mv_t1");
    add_vec(1, I_ILL, 0, e_fetch, "ill_t0");
    add_vec(0, I_ILL, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1), "ill_t1");
    add_vec(1, I_MVNZ, 0, e_fetch, "mvnz0_t0");
    add_vec(0, I_MVNZ, 0, e_mvnz0, "mvnz0_t1");
    add_vec(1, I_MVNZ, 1, e_fetch, "mvnz1_t0");
    add_vec(0, I_MVNZ, 1, e_mvnz1, "mvnz1_t1");
    add_vec(0, I_MVNZ, 0, ZERO, "idle2_t0");
    add_vec(1, I_ILL7, 0, e_fetch, "ill7_t0");
    add_vec(0, I_ILL7, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1), "ill7_t1");
    add_vec(0, I_ILL7, 0, ZERO, "idle3_t0");

    foreach (tbl[i]) step(tbl[i].run, tbl[i].ir, tbl[i].gnz, tbl[i].exp, tbl[i].name);

    // Reset in T2 of an add: outputs drop at once, no Done, then a clean fetch.
    step(1, I_ADD12, 0, e_fetch, "abort_t0");
    step(0, I_ADD12, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 1), "abort_t1");
    step(0, I_ADD12, 0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 1), "abort_t2");
    #2;
    Resetn = 1'b0;
    sb.push_back(ZERO);
    #1;
    check("abort_reset_now");
    @(negedge Clock);
    sb.push_back(ZERO);
    check("abort_no_done");
    #1;
    Resetn = 1'b1;
    step(1, I_MV21, 0, e_fetch, "refetch_t0");
    step(0, I_MV21, 0, mk(0, 8'h04, 8'h02, 0, 0, 0, 0, 0, 1, 1), "refetch_t1");
    step(0, I_MV21, 0, ZERO, "refetch_done_t0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
